// File: rtl/dmem_bus_demux_if.sv
// Bus bundle of the data-memory demux: CPU request/response side,
// shared registered request fields and per-target handshakes.
interface dmem_bus_demux_if;
   logic        m_valid;
   logic        m_ready;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_rvalid;
   logic [31:0] m_rdata;
   logic        m_err;

   logic        t_we;
   logic [31:0] t_addr;
   logic [31:0] t_wdata;

   logic        a_valid;
   logic        a_ready;
   logic        a_rvalid;
   logic [31:0] a_rdata;

   logic        b_valid;
   logic        b_ready;
   logic        b_rvalid;
   logic [31:0] b_rdata;

   modport slave (
      input  m_valid, m_we, m_addr, m_wdata,
      input  a_ready, a_rvalid, a_rdata,
      input  b_ready, b_rvalid, b_rdata,
      output m_ready, m_rvalid, m_rdata, m_err,
      output t_we, t_addr, t_wdata,
      output a_valid, b_valid
   );

   modport master (
      output m_valid, m_we, m_addr, m_wdata,
      output a_ready, a_rvalid, a_rdata,
      output b_ready, b_rvalid, b_rdata,
      input  m_ready, m_rvalid, m_rdata, m_err,
      input  t_we, t_addr, t_wdata,
      input  a_valid, b_valid
   );
endinterface

// File: rtl/dmem_bus_demux.sv
// Routes one CPU data request to target A (RAM) or B (MMIO window).
// Define DEMUX_TIMEOUT_EN to bound each target transaction to TIMEOUT cycles.
module dmem_bus_demux #(
   parameter logic [31:0] B_BASE  = 32'h1000_0000,
   parameter logic [31:0] B_MASK  = 32'hF000_0000,
   parameter int          TIMEOUT = 16
) (
   input logic             clk,
   input logic             rst_n,
   dmem_bus_demux_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE,
      REQ_A,
      REQ_B,
      WAIT_A,
      WAIT_B,
      RESP
   } state_t;

   state_t state;
   logic   sel_b;
   logic   misaligned;
   logic   accept;
   logic   tmo_hit;

   assign sel_b      = (bus.m_addr & B_MASK) == B_BASE;
   assign misaligned = |bus.m_addr[1:0];
   assign accept     = (state == IDLE) && bus.m_valid && bus.m_ready;

`ifdef DEMUX_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   logic [15:0] tmo_cnt;

   // tmo_cnt = cycles already spent in REQ_x/WAIT_x for this request
   assign tmo_hit = tmo_cnt == TMO_LAST;

   always_ff @(posedge clk) begin
      if (!rst_n || accept) begin
         tmo_cnt <= '0;
      end else if (state inside {REQ_A, REQ_B, WAIT_A, WAIT_B}) begin
         tmo_cnt <= tmo_cnt + 16'd1;
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = TIMEOUT != 0;
   assign tmo_hit        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         bus.m_ready  <= 1'b0;
         bus.m_rvalid <= 1'b0;
         bus.m_rdata  <= '0;
         bus.m_err    <= 1'b0;
         bus.t_we     <= 1'b0;
         bus.t_addr   <= '0;
         bus.t_wdata  <= '0;
         bus.a_valid  <= 1'b0;
         bus.b_valid  <= 1'b0;
      end else begin
         bus.m_rvalid <= 1'b0;
         unique case (state)
            IDLE: begin
               bus.m_ready <= 1'b1;
               if (accept) begin
                  bus.m_ready <= 1'b0;
                  bus.t_we    <= bus.m_we;
                  bus.t_addr  <= bus.m_addr;
                  bus.t_wdata <= bus.m_wdata;
                  if (misaligned) begin
                     state        <= RESP;
                     bus.m_rvalid <= 1'b1;
                     bus.m_err    <= 1'b1;
                     bus.m_rdata  <= '0;
                  end else if (sel_b) begin
                     state       <= REQ_B;
                     bus.b_valid <= 1'b1;
                  end else begin
                     state       <= REQ_A;
                     bus.a_valid <= 1'b1;
                  end
               end
            end
            REQ_A: begin
               if (tmo_hit) begin
                  bus.a_valid  <= 1'b0;
                  state        <= RESP;
                  bus.m_rvalid <= 1'b1;
                  bus.m_err    <= 1'b1;
                  bus.m_rdata  <= '0;
               end else if (bus.a_ready) begin
                  bus.a_valid <= 1'b0;
                  state       <= WAIT_A;
               end
            end
            REQ_B: begin
               if (tmo_hit) begin
                  bus.b_valid  <= 1'b0;
                  state        <= RESP;
                  bus.m_rvalid <= 1'b1;
                  bus.m_err    <= 1'b1;
                  bus.m_rdata  <= '0;
               end else if (bus.b_ready) begin
                  bus.b_valid <= 1'b0;
                  state       <= WAIT_B;
               end
            end
            WAIT_A: begin
               if (bus.a_rvalid) begin
                  state        <= RESP;
                  bus.m_rvalid <= 1'b1;
                  bus.m_err    <= 1'b0;
                  bus.m_rdata  <= bus.t_we ? '0 : bus.a_rdata;
               end else if (tmo_hit) begin
                  state        <= RESP;
                  bus.m_rvalid <= 1'b1;
                  bus.m_err    <= 1'b1;
                  bus.m_rdata  <= '0;
               end
            end
            WAIT_B: begin
               if (bus.b_rvalid) begin
                  state        <= RESP;
                  bus.m_rvalid <= 1'b1;
                  bus.m_err    <= 1'b0;
                  bus.m_rdata  <= bus.t_we ? '0 : bus.b_rdata;
               end else if (tmo_hit) begin
                  state        <= RESP;
                  bus.m_rvalid <= 1'b1;
                  bus.m_err    <= 1'b1;
                  bus.m_rdata  <= '0;
               end
            end
            RESP: begin
               state       <= IDLE;
               bus.m_ready <= 1'b1;
            end
            default: begin
               state       <= IDLE;
               bus.m_ready <= 1'b0;
               bus.a_valid <= 1'b0;
               bus.b_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule
